// File: rtl/dma_mem_access_if.sv
// dma_mem_access_if: request/response handshake between the DMA sequencer and the memory access block
// master: sequencer side (drives request, address, direction, write data)
// slave:  access block side (drives ack/end strobes and read data)
interface dma_mem_access_if;
  logic        dma_req;
  logic [21:0] dma_addr;
  logic        dma_rnw;
  logic [7:0]  dma_wd;
  logic        dma_ack;
  logic        dma_end;
  logic [7:0]  dma_rd;
  modport master (output dma_req, dma_addr, dma_rnw, dma_wd, input dma_ack, dma_end, dma_rd);
  modport slave (input dma_req, dma_addr, dma_rnw, dma_wd, output dma_ack, dma_end, dma_rd);
endinterface

// File: rtl/dma_mem_access.sv
// dma_mem_access: arbitrates for the memory bus and performs fixed-length DMA read/write accesses
// clk, rst_n (async, active-low); dma: sequencer handshake (slave modport);
// mem_busrq/mem_busgnt: bus ownership; mem_a/mem_dout/mem_doe/mem_dinp/mem_oe_n/mem_we_n: memory pins
module dma_mem_access #(
  parameter int WAIT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  dma_mem_access_if.slave     dma,
  output logic                mem_busrq,
  input  logic                mem_busgnt,
  output logic [21:0]         mem_a,
  output logic [7:0]          mem_dout,
  output logic                mem_doe,
  input  logic [7:0]          mem_dinp,
  output logic                mem_oe_n,
  output logic                mem_we_n
);
  typedef enum logic [1:0] {IDLE, WGNT, ACC} state_t;
  localparam logic [2:0] CNT_INIT = 3'(WAIT - 1);
  state_t      state;
  logic [2:0]  cnt;
  logic        rnw_q;
  logic        end_q;
  logic [7:0]  rd_q;
  logic        acc;
  logic        last;
  logic        ack;
  assign acc = state == ACC;
  assign last = acc && cnt == 3'd0;
  // Grant is only sampled here; losing it mid-access does not abort the access.
  assign ack = dma.dma_req && mem_busgnt && (state == WGNT || last);
  assign dma.dma_ack = ack;
  assign dma.dma_end = end_q;
  assign dma.dma_rd = rd_q;
  assign mem_busrq = state != IDLE;
  assign mem_oe_n = !(acc && rnw_q);
  assign mem_doe = acc && !rnw_q;
  // Write strobe released one cycle early so data is held past the rising edge of we_n.
  assign mem_we_n = !(acc && !rnw_q && cnt != 3'd0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      rnw_q    <= 1'b0;
      end_q    <= 1'b0;
      rd_q     <= 8'd0;
      mem_a    <= 22'd0;
      mem_dout <= 8'd0;
    end else begin
      end_q <= last;
      if (last && rnw_q) rd_q <= mem_dinp;
      if (ack) begin
        mem_a    <= dma.dma_addr;
        mem_dout <= dma.dma_wd;
        rnw_q    <= dma.dma_rnw;
      end
      cnt   <= ack ? CNT_INIT : (acc && cnt != 3'd0) ? cnt - 3'd1 : cnt;
      state <= (ack || (acc && !last)) ? ACC : dma.dma_req ? WGNT : IDLE;
    end
endmodule

// File: tb/tb_dma_mem_access.sv
// tb_dma_mem_access: directed scoreboard bench for dma_mem_access with WAIT=2 and WAIT=3 instances
module tb_dma_mem_access;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic req = 1'b0;
  logic rnw = 1'b0;
  logic gnt = 1'b1;
  logic [21:0] addr = 22'd0;
  logic [7:0] wd = 8'd0;
  always #5 clk = ~clk;
  dma_mem_access_if if2 ();
  dma_mem_access_if if3 ();
  logic [21:0] a2, a3;
  logic [7:0] do2, do3;
  logic br2, br3, doe2, doe3, oe2, oe3, we2, we3;
  assign if2.dma_req = req & ~sel;
  assign if3.dma_req = req & sel;
  assign if2.dma_addr = addr;
  assign if3.dma_addr = addr;
  assign if2.dma_rnw = rnw;
  assign if3.dma_rnw = rnw;
  assign if2.dma_wd = wd;
  assign if3.dma_wd = wd;
  dma_mem_access #(.WAIT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .dma(if2), .mem_busrq(br2), .mem_busgnt(gnt),
    .mem_a(a2), .mem_dout(do2), .mem_doe(doe2), .mem_dinp(a2[7:0] ^ 8'hE0),
    .mem_oe_n(oe2), .mem_we_n(we2)
  );
  dma_mem_access #(.WAIT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .dma(if3), .mem_busrq(br3), .mem_busgnt(gnt),
    .mem_a(a3), .mem_dout(do3), .mem_doe(doe3), .mem_dinp(a3[7:0] ^ 8'hE0),
    .mem_oe_n(oe3), .mem_we_n(we3)
  );
  logic ack, dend, busrq, doe, oe_n, we_n;
  logic [7:0] rd, dout;
  logic [21:0] ma;
  assign ack = sel ? if3.dma_ack : if2.dma_ack;
  assign dend = sel ? if3.dma_end : if2.dma_end;
  assign rd = sel ? if3.dma_rd : if2.dma_rd;
  assign busrq = sel ? br3 : br2;
  assign doe = sel ? doe3 : doe2;
  assign oe_n = sel ? oe3 : oe2;
  assign we_n = sel ? we3 : we2;
  assign dout = sel ? do3 : do2;
  assign ma = sel ? a3 : a2;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rd [2] = '{8'd0, 8'd0};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic r, input logic [21:0] a, input logic [7:0] d, input logic [7:0] erd);
    req = 1'b1;
    rnw = r;
    addr = a;
    wd = d;
    if (r) last_rd[sel] = erd;
    exp_q.push_back(last_rd[sel]);
  endtask
  always @(negedge clk)
    if (rst_n && dend) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL end_unexpected: got dma_end=1 want no pending access");
      end else chk("end_rd", 32'(rd), 32'(exp_q.pop_front()));
    end
  logic rv [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [21:0] av [4] = '{22'h10, 22'h20, 22'h33, 22'h44};
  logic [7:0] dv [4] = '{8'h00, 8'h11, 8'h00, 8'h22};
  logic [7:0] ev [4] = '{8'hF0, 8'h00, 8'hD3, 8'h00};
  initial begin
    int acks[$];
    int ends[$];
    int k;
    logic br_ok;
    step();
    chk("rst_outs", 32'({busrq, ack, dend, doe, oe_n, we_n}), 32'b000011);
    chk("rst_rd", 32'(rd), 0);
    chk("rst_a", 32'(ma), 0);
    chk("rst_dout", 32'(dout), 0);
    rst_n = 1'b1;
    step();
    issue(1'b1, 22'h12345, 8'h00, 8'hA5);
    #1;
    chk("t1_idle_ack", 32'({busrq, ack}), 0);
    step();
    chk("t1_c1_busrq_ack", 32'({busrq, ack}), 32'b11);
    next();
    req = 1'b0;
    step();
    chk("t1_c2_strobes", 32'({ack, oe_n, we_n, doe}), 32'b0010);
    chk("t1_c2_addr", 32'(ma), 32'h12345);
    step();
    chk("t1_c3_oe", 32'(oe_n), 0);
    step();
    chk("t1_c4_end", 32'({dend, oe_n, busrq}), 32'b110);
    chk("t1_c4_rd", 32'(rd), 32'hA5);
    step();
    chk("t1_c5_end_low", 32'(dend), 0);
    sel = 1'b1;
    issue(1'b0, 22'h3FFFFF, 8'h5A, 8'h00);
    step();
    chk("t2_ack", 32'(ack), 1);
    next();
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_doe_we_oe", 32'({doe, we_n, oe_n}), {29'd0, 1'b1, i == 2, 1'b1});
      chk("t2_dout", 32'(dout), 32'h5A);
      chk("t2_addr", 32'(ma), 32'h3FFFFF);
    end
    step();
    chk("t2_end", 32'({dend, doe}), 32'b10);
    step();
    sel = 1'b0;
    step();
    k = 0;
    br_ok = 1'b1;
    issue(rv[0], av[0], dv[0], ev[0]);
    for (int c = 1; c < 12; c++) begin
      step();
      if (dend) ends.push_back(c);
      if (c <= 9) br_ok &= busrq;
      if (c == 10) chk("t3_busrq_fall", 32'(busrq), 0);
      if (ack) begin
        acks.push_back(c);
        k++;
        next();
        if (k < 4) issue(rv[k], av[k], dv[k], ev[k]);
        else req = 1'b0;
      end
    end
    chk("t3_busrq_high", 32'(br_ok), 1);
    chk("t3_ack_count", acks.size(), 4);
    chk("t3_end_count", ends.size(), 4);
    for (int i = 0; i < acks.size(); i++) chk("t3_ack_cycle", acks[i], 1 + 2 * i);
    for (int i = 0; i < ends.size(); i++) chk("t3_end_cycle", ends[i], 4 + 2 * i);
    step();
    gnt = 1'b0;
    issue(1'b1, 22'h55, 8'h00, 8'hB5);
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("t4_wait_gnt", 32'({ack, busrq, oe_n, we_n, doe}), 32'b01110);
    end
    next();
    gnt = 1'b1;
    step();
    chk("t4_ack_on_gnt", 32'(ack), 1);
    next();
    req = 1'b0;
    step();
    gnt = 1'b0;
    chk("t4_acc_oe", 32'(oe_n), 0);
    step();
    chk("t4_acc_oe2", 32'(oe_n), 0);
    step();
    chk("t4_end_no_gnt", 32'(dend), 1);
    gnt = 1'b1;
    step();
    sel = 1'b1;
    issue(1'b0, 22'h77, 8'h99, 8'h00);
    step();
    chk("t5_ack", 32'(ack), 1);
    next();
    req = 1'b0;
    step();
    chk("t5_acc_we", 32'({we_n, doe}), 32'b01);
    rst_n = 1'b0;
    exp_q.delete();
    last_rd = '{8'd0, 8'd0};
    #1;
    chk("t5_rst_strobes", 32'({we_n, doe, busrq}), 32'b100);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_no_end", 32'({dend, busrq}), 0);
    end
    issue(1'b1, 22'h01, 8'h00, 8'hE1);
    step();
    chk("t5_new_ack", 32'(ack), 1);
    next();
    req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    step();
    chk("t5_new_end", 32'(dend), 1);
    step();
    sel = 1'b0;
    gnt = 1'b0;
    req = 1'b1;
    rnw = 1'b1;
    step();
    chk("t6_wgnt", 32'({busrq, ack}), 32'b10);
    req = 1'b0;
    step();
    chk("t6_busrq_drop", 32'(busrq), 0);
    for (int i = 0; i < 3; i++) step();
    gnt = 1'b1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dma_mem_access.md
DMA_MEM_ACCESS -- requirements
Module: dma_mem_access

Interface
REQ-001 Parameter WAIT, default 2: memory access length in clocks; legal range 2..7.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 dma_req  in  1  access request from the DMA sequencer; held until acked.
REQ-005 dma_addr  in  22  access address, valid while dma_req=1.
REQ-006 dma_rnw  in  1  1=read, 0=write, valid while dma_req=1.
REQ-007 dma_wd  in  8  write data, valid while dma_req=1.
REQ-008 dma_ack  out  1  one-cycle accept strobe; sequencer may change request on the next edge.
REQ-009 dma_end  out  1  one-cycle completion strobe for the oldest accepted access.
REQ-010 dma_rd  out  8  read data, valid while dma_end=1 for a read; held until the next read completes.
REQ-011 mem_busrq  out  1  request for ownership of the memory bus.
REQ-012 mem_busgnt  in  1  bus granted to this block.
REQ-013 mem_a  out  22  memory address.
REQ-014 mem_dout  out  8  memory write data.
REQ-015 mem_doe  out  1  write data output enable.
REQ-016 mem_dinp  in  8  memory read data.
REQ-017 mem_oe_n  out  1  memory read strobe, active-low.
REQ-018 mem_we_n  out  1  memory write strobe, active-low.

Function
REQ-019 FSM states: IDLE, WGNT (bus requested, awaiting grant or request), ACC (access in progress, down-counter cnt).
REQ-020 IDLE: mem_busrq=0; dma_req=1 -> WGNT on next edge; no ack issued in IDLE.
REQ-021 WGNT: mem_busrq=1; dma_ack = dma_req & mem_busgnt (combinational); on ack -> ACC with cnt=WAIT-1.
REQ-022 WGNT with dma_req=0 -> IDLE on next edge.
REQ-023 On every ack edge: latch dma_addr, dma_rnw, dma_wd into internal registers; mem_a/mem_dout driven only from these registers.
REQ-024 ACC: mem_busrq=1; cnt decrements each cycle; cycle with cnt=0 is the last access cycle.
REQ-025 ACC read: mem_oe_n=0 for all WAIT cycles; mem_doe=0; mem_we_n=1.
REQ-026 ACC write: mem_doe=1 for all WAIT cycles; mem_we_n=0 for all cycles except the last (data hold); mem_oe_n=1.
REQ-027 Last ACC cycle: read latches mem_dinp into dma_rd at the closing edge; dma_end=1 (registered) in the following cycle, for reads and writes alike.
REQ-028 Last ACC cycle with dma_req=1 and mem_busgnt=1: dma_ack=1 in that cycle; new access latched; ACC restarts with cnt=WAIT-1 (back-to-back, no idle cycle; the previous access's dma_end coincides with the first cycle of the new access).
REQ-029 Last ACC cycle otherwise: dma_req=1 -> WGNT; dma_req=0 -> IDLE (mem_busrq falls next cycle).
REQ-030 dma_ack is 0 in any cycle not in WGNT or last ACC cycle; never two acks without an intervening ACC of WAIT cycles.
REQ-031 mem_busgnt falling during ACC is ignored: the access completes normally; grant checked only at ack.
REQ-032 Latency from idle, grant already present: req seen cycle 0 -> ack cycle 1 -> ACC cycles 2..WAIT+1 -> dma_end cycle WAIT+2.
REQ-033 Outside ACC: mem_oe_n=1, mem_we_n=1, mem_doe=0; mem_a holds last latched address.

Reset
REQ-034 rst_n=0 asynchronously forces: state IDLE, cnt=0, mem_busrq=0, dma_ack=0, dma_end=0, dma_rd=0, mem_a=0, mem_dout=0, mem_doe=0, mem_oe_n=1, mem_we_n=1.
REQ-035 Reset asserted mid-access aborts the access with no dma_end; after release the block is in IDLE.

Verification
REQ-036 WAIT=2, gnt tied 1, read addr 0x12345, mem_dinp=0xA5 -> busrq & ack cycle 1, mem_oe_n=0 cycles 2-3, dma_end cycle 4 with dma_rd=0xA5.
REQ-037 WAIT=3, write addr 0x3FFFFF data 0x5A -> mem_doe=1 three cycles, mem_we_n=0 first two only, mem_dout=0x5A, dma_end one cycle after ACC.
REQ-038 Four back-to-back requests (read, write, read, write), gnt=1, WAIT=2 -> ack every 2 cycles, four dma_end strobes every 2 cycles, busrq continuously high, falls after last access.
REQ-039 Grant withheld 5 cycles after busrq -> no ack, mem strobes idle; ack in first cycle gnt=1; grant dropped mid-ACC -> access still completes with dma_end.
REQ-040 rst_n asserted in first ACC cycle of a write -> mem_we_n=1, mem_doe=0 immediately, no dma_end; new request after release serviced normally.
REQ-041 Request withdrawn in WGNT before grant -> IDLE, busrq=0 next cycle, no ack, no dma_end.
